// File: rtl/activity_tracker.sv
// activity_tracker
//   Step/activity statistics core. Steps come from an internal rate generator
//   (mode 0..2) or from a synchronised external step_in (mode 3). The core
//   keeps the total step count and the distance. It tracks initial-window and
//   high-activity seconds and rotates a display selector.
//   FSM: IDLE -> RUN <-> PAUSE. Statistics only move in RUN.
//
//   Optional feature macro: PEAK_RATE_EN adds peak_rate (max steps/second).
//
// Ports
//   clk, reset_n   clock, async active-low reset
//   start          level: 1 = run, 0 = pause
//   mode           0/1/2 internal generator at RATE0/1/2, 3 = external step_in
//   step_in        asynchronous external step signal
//   step_count     total steps (saturating)
//   distance       steps / STEPS_PER_UNIT (saturating)
//   init_count     qualifying seconds inside the initial window
//   high_time      accumulated high-activity seconds (saturating)
//   disp_sel       display item selector, rotates every DISP_SEC seconds
//   sat            step_count > SAT_LIMIT
//   running        FSM in RUN
//   peak_rate      (PEAK_RATE_EN only) highest per-second step count seen
module activity_tracker #(
    parameter int CLK_HZ         = 100000000,
    parameter int STEP_W         = 32,
    parameter int RATE0          = 32,
    parameter int RATE1          = 64,
    parameter int RATE2          = 128,
    parameter int STEPS_PER_UNIT = 1024,
    parameter int INIT_WINDOW_S  = 9,
    parameter int INIT_THRESH    = 32,
    parameter int HIGH_RATE      = 64,
    parameter int HIGH_MIN_S     = 60,
    parameter int SAT_LIMIT      = 9999,
    parameter int DISP_SEC       = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic              step_in,
    output logic [STEP_W-1:0] step_count,
    output logic [15:0]       distance,
    output logic [7:0]        init_count,
    output logic [15:0]       high_time,
    output logic [1:0]        disp_sel,
    output logic              sat,
`ifdef PEAK_RATE_EN
    output logic [15:0]       peak_rate,
`endif
    output logic              running
);

    localparam logic [31:0] SEC_LAST  = 32'(CLK_HZ - 1);
    localparam logic [31:0] GEN_LAST0 = 32'(CLK_HZ / RATE0 - 1);
    localparam logic [31:0] GEN_LAST1 = 32'(CLK_HZ / RATE1 - 1);
    localparam logic [31:0] GEN_LAST2 = 32'(CLK_HZ / RATE2 - 1);
    localparam logic [31:0] SPU_LAST  = 32'(STEPS_PER_UNIT - 1);
    localparam logic [31:0] INIT_WIN  = 32'(INIT_WINDOW_S);
    localparam logic [31:0] INIT_TH   = 32'(INIT_THRESH);
    localparam logic [31:0] HI_TH     = 32'(HIGH_RATE);
    localparam logic [31:0] HI_MIN    = 32'(HIGH_MIN_S);
    localparam logic [16:0] HI_MIN_AD = 17'(HIGH_MIN_S);
    localparam logic [31:0] DISP_LAST = 32'(DISP_SEC - 1);
    localparam logic [63:0] SAT_LIM   = 64'(SAT_LIMIT);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE} state_e;

    state_e            state_q, state_d;
    logic [1:0]        mode_q;
    logic [2:0]        sync_q;
    logic [31:0]       sec_q, sec_d, gen_q, gen_d, sub_q, sub_d;
    logic [31:0]       initsec_q, initsec_d, run_q, run_d, dcnt_q, dcnt_d;
    logic [STEP_W-1:0] steps_q, steps_d;
    logic [15:0]       dist_q, dist_d, bucket_q, bucket_d, high_q, high_d;
    logic [7:0]        init_q, init_d;
    logic [1:0]        disp_q, disp_d;
`ifdef PEAK_RATE_EN
    logic [15:0]       peak_q, peak_d;
`endif

    logic        run, start_run, mode_chg, gen_hit, ext_hit, step_pulse, tick;
    logic [31:0] gen_last, run_inc;
    logic [15:0] bucket_eff;
    logic [16:0] high_sum;

    // ---------------- FSM ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start)  state_d = S_RUN;
            S_RUN:   if (!start) state_d = S_PAUSE;
            S_PAUSE: if (start)  state_d = S_RUN;
            default: state_d = S_IDLE;
        endcase
    end

    assign run       = (state_q == S_RUN);
    assign start_run = (state_q == S_IDLE) && start;

    // ---------------- step sources ----------------
    always_comb begin
        case (mode)
            2'd0:    gen_last = GEN_LAST0;
            2'd1:    gen_last = GEN_LAST1;
            default: gen_last = GEN_LAST2;
        endcase
    end

    // A mode change restarts the generator phase; suppress a coincidental
    // hit in that same cycle so the new rate starts from a clean period.
    assign mode_chg   = (mode != mode_q);
    assign gen_hit    = (mode != 2'd3) && !mode_chg && (gen_q == gen_last);
    assign ext_hit    = (mode == 2'd3) && sync_q[1] && !sync_q[2];
    assign step_pulse = run && (gen_hit || ext_hit);
    assign tick       = run && (sec_q == SEC_LAST);

    // Steps landing on the tick cycle belong to the second that is ending.
    assign bucket_eff = (step_pulse && bucket_q != '1) ? bucket_q + 16'd1 : bucket_q;
    assign run_inc    = (run_q != '1) ? run_q + 32'd1 : run_q;

    // ---------------- datapath next state ----------------
    always_comb begin
        sec_d     = sec_q;
        gen_d     = gen_q;
        sub_d     = sub_q;
        initsec_d = initsec_q;
        run_d     = run_q;
        dcnt_d    = dcnt_q;
        steps_d   = steps_q;
        dist_d    = dist_q;
        bucket_d  = bucket_eff;
        high_d    = high_q;
        init_d    = init_q;
        disp_d    = disp_q;
        high_sum  = {1'b0, high_q};
`ifdef PEAK_RATE_EN
        peak_d    = peak_q;
`endif

        if (start_run)
            sec_d = '0;
        else if (run)
            sec_d = tick ? '0 : sec_q + 32'd1;

        if (start_run || mode_chg)
            gen_d = '0;
        else if (run && mode != 2'd3)
            gen_d = gen_hit ? '0 : gen_q + 32'd1;

        if (step_pulse) begin
            if (steps_q != '1) steps_d = steps_q + 1'b1;
            if (sub_q == SPU_LAST) begin
                sub_d = '0;
                if (dist_q != '1) dist_d = dist_q + 16'd1;
            end else begin
                sub_d = sub_q + 32'd1;
            end
        end

        if (start_run) begin
            bucket_d  = '0;
            initsec_d = '0;
        end

        if (tick) begin
            bucket_d = '0;

            if (initsec_q < INIT_WIN) begin
                initsec_d = initsec_q + 32'd1;
                if ({16'd0, bucket_eff} > INIT_TH && init_q != '1)
                    init_d = init_q + 8'd1;
            end

            // A run earns HIGH_MIN_S in one go when it first qualifies, then
            // one second per additional high second.
            if ({16'd0, bucket_eff} > HI_TH) begin
                run_d = run_inc;
                if (run_inc == HI_MIN)
                    high_sum = {1'b0, high_q} + HI_MIN_AD;
                else if (run_inc > HI_MIN)
                    high_sum = {1'b0, high_q} + 17'd1;
                high_d = high_sum[16] ? '1 : high_sum[15:0];
            end else begin
                run_d = '0;
            end

            if (dcnt_q >= DISP_LAST) begin
                dcnt_d = '0;
                disp_d = disp_q + 2'd1;
            end else begin
                dcnt_d = dcnt_q + 32'd1;
            end

`ifdef PEAK_RATE_EN
            if (bucket_eff > peak_q) peak_d = bucket_eff;
`endif
        end
    end

    // ---------------- registers ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            mode_q    <= '0;
            sync_q    <= '0;
            sec_q     <= '0;
            gen_q     <= '0;
            sub_q     <= '0;
            initsec_q <= '0;
            run_q     <= '0;
            dcnt_q    <= '0;
            steps_q   <= '0;
            dist_q    <= '0;
            bucket_q  <= '0;
            high_q    <= '0;
            init_q    <= '0;
            disp_q    <= '0;
`ifdef PEAK_RATE_EN
            peak_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            mode_q    <= mode;
            sync_q    <= {sync_q[1:0], step_in};
            sec_q     <= sec_d;
            gen_q     <= gen_d;
            sub_q     <= sub_d;
            initsec_q <= initsec_d;
            run_q     <= run_d;
            dcnt_q    <= dcnt_d;
            steps_q   <= steps_d;
            dist_q    <= dist_d;
            bucket_q  <= bucket_d;
            high_q    <= high_d;
            init_q    <= init_d;
            disp_q    <= disp_d;
`ifdef PEAK_RATE_EN
            peak_q    <= peak_d;
`endif
        end
    end

    assign step_count = steps_q;
    assign distance   = dist_q;
    assign init_count = init_q;
    assign high_time  = high_q;
    assign disp_sel   = disp_q;
    assign sat        = 64'(steps_q) > SAT_LIM;
    assign running    = run;
`ifdef PEAK_RATE_EN
    assign peak_rate  = peak_q;
`endif

endmodule

// File: tb/tb_activity_tracker.sv
// Directed bench for activity_tracker (CLK_HZ=3200, HIGH_MIN_S=3, SAT_LIMIT=100).
// A second instance with STEP_W=8 sees the same stimulus to exercise
// step_count saturation. Expected values are queued as each step is driven
// and popped when the DUT result is sampled.
module tb_activity_tracker;

    localparam int HZ = 3200;

    logic        clk = 1'b0;
    logic        reset_n, start, step_in;
    logic [1:0]  mode;
    logic [31:0] step_count;
    logic [7:0]  step_count8;
    logic [15:0] distance, high_time, distance8, high_time8;
    logic [7:0]  init_count, init_count8;
    logic [1:0]  disp_sel, disp_sel8;
    logic        sat, running, sat8, running8;
`ifdef PEAK_RATE_EN
    logic [15:0] peak_rate, peak_rate8;
`endif

    always #5 clk = ~clk;

    activity_tracker #(.CLK_HZ(HZ), .HIGH_MIN_S(3), .SAT_LIMIT(100)) u_dut (
        .clk(clk), .reset_n(reset_n), .start(start), .mode(mode), .step_in(step_in),
        .step_count(step_count), .distance(distance), .init_count(init_count),
        .high_time(high_time), .disp_sel(disp_sel), .sat(sat),
`ifdef PEAK_RATE_EN
        .peak_rate(peak_rate),
`endif
        .running(running));

    activity_tracker #(.CLK_HZ(HZ), .STEP_W(8), .HIGH_MIN_S(3), .SAT_LIMIT(100)) u_dut8 (
        .clk(clk), .reset_n(reset_n), .start(start), .mode(mode), .step_in(step_in),
        .step_count(step_count8), .distance(distance8), .init_count(init_count8),
        .high_time(high_time8), .disp_sel(disp_sel8), .sat(sat8),
`ifdef PEAK_RATE_EN
        .peak_rate(peak_rate8),
`endif
        .running(running8));

    typedef struct {
        string       tag;
        int          steps;
        int          init;
        int          high;
        int          disp;
        logic        run;
    } exp_t;

    exp_t sbq[$];
    int   vectors = 0;
    int   miscompares = 0;

    function automatic void push_exp(string tag, int steps, int init, int high, int disp, logic run);
        exp_t e;
        e.tag = tag; e.steps = steps; e.init = init; e.high = high; e.disp = disp; e.run = run;
        sbq.push_back(e);
    endfunction

    task automatic check();
        exp_t        e;
        logic [31:0] x_steps;
        logic [7:0]  x_steps8;
        logic [15:0] x_dist, x_high;
        logic [7:0]  x_init;
        logic [1:0]  x_disp;
        logic        x_sat;
        if (sbq.size() == 0) begin
            vectors++; miscompares++;
            $error("FAIL scoreboard_empty: got 0 entries required 1");
            return;
        end
        e        = sbq.pop_front();
        x_steps  = 32'(e.steps);
        x_steps8 = (e.steps > 255) ? 8'd255 : 8'(e.steps);
        x_dist   = 16'(e.steps / 1024);
        x_init   = 8'(e.init);
        x_high   = 16'(e.high);
        x_disp   = 2'(e.disp);
        x_sat    = (e.steps > 100);
        vectors += 9;
        assert (step_count === x_steps) else begin miscompares++;
            $error("FAIL %s.step_count got %0d required %0d", e.tag, step_count, x_steps); end
        assert (step_count8 === x_steps8) else begin miscompares++;
            $error("FAIL %s.step_count8 got %0d required %0d", e.tag, step_count8, x_steps8); end
        assert (distance === x_dist) else begin miscompares++;
            $error("FAIL %s.distance got %0d required %0d", e.tag, distance, x_dist); end
        assert (init_count === x_init) else begin miscompares++;
            $error("FAIL %s.init_count got %0d required %0d", e.tag, init_count, x_init); end
        assert (high_time === x_high) else begin miscompares++;
            $error("FAIL %s.high_time got %0d required %0d", e.tag, high_time, x_high); end
        assert (disp_sel === x_disp) else begin miscompares++;
            $error("FAIL %s.disp_sel got %0d required %0d", e.tag, disp_sel, x_disp); end
        assert (sat === x_sat) else begin miscompares++;
            $error("FAIL %s.sat got %0b required %0b", e.tag, sat, x_sat); end
        assert (running === e.run) else begin miscompares++;
            $error("FAIL %s.running got %0b required %0b", e.tag, running, e.run); end
        assert (sat8 === (x_steps8 > 8'd100)) else begin miscompares++;
            $error("FAIL %s.sat8 got %0b required %0b", e.tag, sat8, (x_steps8 > 8'd100)); end
    endtask

    // Start (or resume) and leave exactly n RUN cycles counted, ending paused.
    task automatic run_for(input int n);
        start = 1'b1;
        @(posedge clk);
        repeat (n - 1) @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic reset_idle();
        start   = 1'b0;
        step_in = 1'b0;
        reset_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b1; start = 1'b0; mode = 2'd0; step_in = 1'b0;
        #1 reset_n = 1'b0;
        #1;
        push_exp("reset", 0, 0, 0, 0, 1'b0); check();
        @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk);
        #1;

        // ---- A: mode 0 with a pause mid-second, resume, async reset ----
        mode = 2'd0;
        push_exp("A_pause", 80, 0, 0, 1, 1'b0);
        run_for(8050); check();
        push_exp("A_held", 80, 0, 0, 1, 1'b0);
        repeat (5000) @(posedge clk);
        #1 check();
        push_exp("A_resume", 128, 0, 0, 2, 1'b1);
        start = 1'b1;
        @(posedge clk);
        repeat (4750) @(posedge clk);
        #1 check();
        push_exp("A_async_rst", 0, 0, 0, 0, 1'b0);
        repeat (1234) @(posedge clk);
        #3 reset_n = 1'b0;
        #1 check();
        reset_idle();

        // ---- B: mode 1, 64 steps/s: qualifies for init, never high ----
        mode = 2'd1;
        push_exp("B_5s", 320, 5, 0, 2, 1'b0);
        run_for(5 * HZ); check();
        push_exp("B_9s", 576, 9, 0, 0, 1'b0);
        run_for(4 * HZ); check();
        reset_idle();

        // ---- C: mode 2 high run, break, short run, distance, disp rotation ----
        mode = 2'd2;
        for (int s = 1; s <= 5; s++) begin
            push_exp($sformatf("C_m2_%0ds", s), 128 * s, s, (s >= 3) ? s : 0, s / 2, 1'b0);
            run_for(HZ); check();
        end
        mode = 2'd0;
        push_exp("C_m0_6s", 672, 5, 5, 3, 1'b0);
        run_for(HZ); check();
        mode = 2'd2;
        push_exp("C_m2_7s", 800, 6, 5, 3, 1'b0);
        run_for(HZ); check();
        push_exp("C_m2_8s", 928, 7, 5, 0, 1'b0);
        run_for(HZ); check();
        push_exp("C_m2_9s", 1056, 8, 8, 0, 1'b0);
        run_for(HZ); check();
        push_exp("C_m2_10s", 1184, 8, 9, 1, 1'b0);
        run_for(HZ); check();
        reset_idle();

        // ---- D: external steps, latency and sat boundary ----
        mode  = 2'd3;
        start = 1'b1;
        @(posedge clk);
        #1 step_in = 1'b1;
        @(posedge clk);
        @(posedge clk);
        push_exp("D_lat2", 0, 0, 0, 0, 1'b1);
        #1 check();
        @(posedge clk);
        push_exp("D_lat3", 1, 0, 0, 0, 1'b1);
        #1 check();
        @(posedge clk);
        #1 step_in = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        for (int p = 2; p <= 101; p++) begin
            step_in = 1'b1;
            repeat (4) @(posedge clk);
            #1 step_in = 1'b0;
            repeat (4) @(posedge clk);
            #1;
            if (p == 100) begin
                push_exp("D_100", 100, 0, 0, 0, 1'b1); check();
            end
        end
        push_exp("D_101", 101, 0, 0, 0, 1'b1); check();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
